// File: rtl/pll_rstseq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rstseq_pkg;

    localparam int unsigned RETRY_W = 4;

    typedef logic [RETRY_W-1:0] retry_t;

    typedef enum logic [4:0] {
        PLL_RST   = 5'b00001,
        WAIT_LOCK = 5'b00010,
        STABLE    = 5'b00100,
        RUN       = 5'b01000,
        FAULT     = 5'b10000
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high clear.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input; clear empties both stages.
    always_ff @(posedge clk) begin
        if (clear) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset. Retries on timeout or lock loss and latches
// a fault once the retry budget is spent.
// Optional feature: define PLL_RSTSEQ_LOSS_FILTER_EN to require a persistent
// lock dropout (LOSS_FILTER_CYCLES) in RUN before declaring loss.
module pll_reset_sequencer
    import pll_rstseq_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned LOSS_FILTER_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    output logic               pll_resetn,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned CNT_MAX = max_u(max_u(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES),
                                            max_u(LOCK_TIMEOUT_CYCLES, LOSS_FILTER_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t   RST_LAST  = cnt_t'(PLL_RESET_CYCLES - 1);
    localparam cnt_t   TMO_LAST  = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t   STB_DONE  = cnt_t'(LOCK_STABLE_CYCLES);
    localparam retry_t RETRY_MAX = retry_t'(MAX_RETRIES);
`ifdef PLL_RSTSEQ_LOSS_FILTER_EN
    localparam cnt_t   LOSS_LAST = cnt_t'(LOSS_FILTER_CYCLES - 1);
`endif

    state_t state, state_nx;
    cnt_t   cnt, cnt_nx;
    retry_t retry_nx;
    logic   locked_s;
    logic   fail;
    logic   run_hold;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .clear (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        retry_nx = retry_count;
        fail     = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock has priority over a coincident timeout.
                if (locked_s) begin
                    state_nx = STABLE;
                    cnt_nx   = cnt_t'(1);
                end else if (cnt == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STB_DONE) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
            end
            RUN: begin
`ifdef PLL_RSTSEQ_LOSS_FILTER_EN
                // Counter tracks consecutive unlocked samples while running.
                if (locked_s) begin
                    cnt_nx = '0;
                end else if (cnt == LOSS_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
`else
                if (!locked_s) begin
                    fail = 1'b1;
                end
`endif
            end
            FAULT: begin
                state_nx = FAULT;
            end
            default: begin
                state_nx = PLL_RST;
                cnt_nx   = '0;
            end
        endcase

        if (fail) begin
            retry_nx = retry_count + retry_t'(1);
            cnt_nx   = '0;
            state_nx = (retry_nx == RETRY_MAX) ? FAULT : PLL_RST;
        end
    end

    // Release needs a second RUN cycle with lock still present; leaving RUN
    // reasserts reset on the same edge that exits the state.
    assign run_hold = (state == RUN) && (state_nx == RUN);

    // State register and registered outputs; reset overrides any coincident event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLL_RST;
            cnt         <= '0;
            retry_count <= '0;
            pll_resetn  <= 1'b0;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry_count <= retry_nx;
            pll_resetn  <= (state_nx inside {WAIT_LOCK, STABLE, RUN});
            sys_reset   <= !run_hold;
            ready       <= run_hold;
            fault       <= (state_nx == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer. Expected latencies are queued
// when stimulus is applied and popped when the DUT output responds.
module tb_pll_reset_sequencer;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_STB  = 8;
    localparam int unsigned P_TMO  = 100;
    localparam int unsigned P_MAX  = 2;
    localparam int unsigned P_LOSS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_resetn;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        string       name;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TMO),
        .MAX_RETRIES         (P_MAX),
        .LOSS_FILTER_CYCLES  (P_LOSS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .pll_resetn  (pll_resetn),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Waits (sampling on negedges) until the selected output equals val.
    // lat = number of posedges since call; 32'hFFFFFFFF if the bound expired.
    task automatic wait_level(input int sel, input logic val, input int unsigned limit,
                              output int unsigned lat);
        logic cur;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            case (sel)
                0:       cur = pll_resetn;
                1:       cur = sys_reset;
                2:       cur = ready;
                default: cur = fault;
            endcase
        end while (cur !== val && lat < limit);
        if (cur !== val) lat = 32'hFFFF_FFFF;
    endtask

    task automatic bring_up();
        int unsigned lat;
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (P_RST + 2) @(negedge clk);
        pll_locked = 1'b1;
        wait_level(2, 1'b1, P_STB + 60, lat);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pll_resetn !== 1'b0) $display("FAIL reset_pll_resetn: got %b, expected 0", pll_resetn); else n_pass++;
        n_checks++; if (sys_reset !== 1'b1) $display("FAIL reset_sys_reset: got %b, expected 1", sys_reset); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", ready); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b, expected 0", fault); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL reset_retry: got %0d, expected 0", retry_count); else n_pass++;
    endtask

    task automatic test_nominal();
        int unsigned lat;
        exp_t e;
        sb.push_back('{name: "nominal_resetn_rise", lat: P_RST});
        reset = 1'b0;
        wait_level(0, 1'b1, P_RST + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        repeat (20 - P_RST) @(negedge clk);
        // first sampling edge is 1 posedge away; release follows it by STABLE+3
        sb.push_back('{name: "nominal_release", lat: P_STB + 4});
        pll_locked = 1'b1;
        wait_level(1, 1'b0, P_STB + 60, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL nominal_ready: got %b, expected 1", ready); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL nominal_retry: got %0d, expected 0", retry_count); else n_pass++;
        n_checks++; if (pll_resetn !== 1'b1) $display("FAIL nominal_pll_resetn: got %b, expected 1", pll_resetn); else n_pass++;
    endtask

    task automatic test_glitch();
        int unsigned lat;
        exp_t e;
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_level(0, 1'b1, P_RST + 50, lat);
        pll_locked = 1'b1;
        repeat (7) @(negedge clk);   // stable count has reached 5
        pll_locked = 1'b0;
        @(negedge clk);
        sb.push_back('{name: "glitch_release", lat: P_STB + 4});
        pll_locked = 1'b1;
        wait_level(1, 1'b0, P_STB + 60, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL glitch_retry: got %0d, expected 0", retry_count); else n_pass++;
    endtask

    task automatic test_timeout();
        int unsigned lat;
        int unsigned bad;
        exp_t e;
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_level(0, 1'b1, P_RST + 50, lat);
        sb.push_back('{name: "timeout1", lat: P_TMO});
        wait_level(0, 1'b0, P_TMO + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL timeout1_retry: got %0d, expected 1", retry_count); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL timeout1_fault: got %b, expected 0", fault); else n_pass++;
        sb.push_back('{name: "timeout1_repulse", lat: P_RST});
        wait_level(0, 1'b1, P_RST + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        sb.push_back('{name: "timeout2_fault", lat: P_TMO});
        wait_level(3, 1'b1, P_TMO + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        n_checks++; if (retry_count !== 4'd2) $display("FAIL fault_retry: got %0d, expected 2", retry_count); else n_pass++;
        n_checks++; if (pll_resetn !== 1'b0) $display("FAIL fault_pll_resetn: got %b, expected 0", pll_resetn); else n_pass++;
        n_checks++; if (sys_reset !== 1'b1) $display("FAIL fault_sys_reset: got %b, expected 1", sys_reset); else n_pass++;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 500) pll_locked = 1'b1;   // late lock must not leave FAULT
            if (fault !== 1'b1 || pll_resetn !== 1'b0 || sys_reset !== 1'b1 ||
                ready !== 1'b0 || retry_count !== 4'd2) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL fault_sticky: %0d bad cycles, expected 0", bad); else n_pass++;
    endtask

    task automatic test_lock_loss();
        int unsigned lat;
        int unsigned bad;
        int unsigned t;
        exp_t e;
        bring_up();
`ifdef PLL_RSTSEQ_LOSS_FILTER_EN
        pll_locked = 1'b0;
        repeat (P_LOSS - 1) @(negedge clk);
        pll_locked = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready !== 1'b1 || sys_reset !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL filter_short_dropout: %0d cycles not ready, expected 0", bad); else n_pass++;
        sb.push_back('{name: "filter_loss", lat: P_LOSS + 2});
        pll_locked = 1'b0;
        repeat (P_LOSS) @(negedge clk);
        pll_locked = 1'b1;
        t = P_LOSS;
        wait_level(1, 1'b1, 40, lat);
        if (lat != 32'hFFFF_FFFF) lat = lat + t;
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
`else
        sb.push_back('{name: "loss_sys_reset", lat: 3});
        pll_locked = 1'b0;
        wait_level(1, 1'b1, 40, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        pll_locked = 1'b1;
`endif
        n_checks++; if (ready !== 1'b0) $display("FAIL loss_ready: got %b, expected 0", ready); else n_pass++;
        n_checks++; if (pll_resetn !== 1'b0) $display("FAIL loss_pll_resetn: got %b, expected 0", pll_resetn); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL loss_retry: got %0d, expected 1", retry_count); else n_pass++;
        sb.push_back('{name: "loss_repulse", lat: P_RST});
        wait_level(0, 1'b1, P_RST + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        // lock already present: STABLE on the next edge, release STABLE+1 after that
        sb.push_back('{name: "loss_rerelease", lat: P_STB + 2});
        wait_level(1, 1'b0, P_STB + 60, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        n_checks++; if (retry_count !== 4'd1) $display("FAIL loss_retry_after: got %0d, expected 1", retry_count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int unsigned lat;
        exp_t e;
        // reset while in STABLE
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_level(0, 1'b1, P_RST + 50, lat);
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (pll_resetn !== 1'b0) $display("FAIL stable_rst_pll_resetn: got %b, expected 0", pll_resetn); else n_pass++;
        n_checks++; if (sys_reset !== 1'b1 || ready !== 1'b0) $display("FAIL stable_rst_sys: got %b/%b, expected 1/0", sys_reset, ready); else n_pass++;
        // reset while in FAULT
        pll_locked = 1'b0;
        @(negedge clk);
        sb.push_back('{name: "fault_entry", lat: 2 * (P_RST + P_TMO)});
        reset = 1'b0;
        wait_level(3, 1'b1, 2 * (P_RST + P_TMO) + 50, lat);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL %s: latency %0d, expected %0d", e.name, lat, e.lat); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (fault !== 1'b0) $display("FAIL fault_rst_fault: got %b, expected 0", fault); else n_pass++;
        n_checks++; if (retry_count !== 4'd0) $display("FAIL fault_rst_retry: got %0d, expected 0", retry_count); else n_pass++;
        n_checks++; if (pll_resetn !== 1'b0 || sys_reset !== 1'b1) $display("FAIL fault_rst_outs: got %b/%b, expected 0/1", pll_resetn, sys_reset); else n_pass++;
        // lock loss coinciding with reset: reset wins, no retry recorded
        bring_up();
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (retry_count !== 4'd0) $display("FAIL loss_vs_reset_retry: got %0d, expected 0", retry_count); else n_pass++;
        n_checks++; if (fault !== 1'b0 || ready !== 1'b0) $display("FAIL loss_vs_reset_outs: got %b/%b, expected 0/0", fault, ready); else n_pass++;
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
